// File: rtl/beta_encoder.sv
// ---------------------------------------------------------------------------
// beta_encoder
// Purpose : builds 32-bit RV32I instruction words from field-level requests.
//           It is the exact inverse of beta_decoder, so decoding instr_o gives
//           back the requested rs1/rs2/rd/imm. It also expands the LI
//           pseudo-op into a single ADDI, a single LUI, or LUI followed by
//           ADDI on two output beats.
// Ports   :
//   clk_i, rst_i             clock and synchronous active-high reset
//   req_valid_i/req_ready_o  request handshake
//   req_kind_i               0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 LI, 7 reserved
//   opcode5_i, funct3_i,
//   funct7b5_i               opcode[6:2], funct3 and funct7[5]
//   rs1_i, rs2_i, rd_i       register numbers
//   imm_i                    two's complement immediate / LI value
//   instr_valid_o/instr_ready_i/instr_o  registered output word stream
//   invalid_o                one-cycle pulse when the last accepted
//                            request was dropped
// Only XLEN = 32 is supported.
// ---------------------------------------------------------------------------
module beta_encoder #(
  parameter int XLEN  = 32,
  parameter bit LI_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_kind_i,
  input  logic [4:0]      opcode5_i,
  input  logic [2:0]      funct3_i,
  input  logic            funct7b5_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] imm_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic            invalid_o
);

  localparam logic [2:0] KIND_R  = 3'd0;
  localparam logic [2:0] KIND_I  = 3'd1;
  localparam logic [2:0] KIND_S  = 3'd2;
  localparam logic [2:0] KIND_B  = 3'd3;
  localparam logic [2:0] KIND_U  = 3'd4;
  localparam logic [2:0] KIND_J  = 3'd5;
  localparam logic [2:0] KIND_LI = 3'd6;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic {
    S_IDLE,
    S_LI_LO
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        invalid_q, invalid_d;
  logic [31:0] addi_q, addi_d;

  logic [6:0]  opc;
  logic        fits12, fits13, fits21;
  logic        is_shift;
  logic [19:0] li_hi;
  logic        req_ok;
  logic        req_two;
  logic [31:0] word_a;
  logic [31:0] word_b;
  logic        req_accept;
  logic        beat_xfer;

  // Range predicates: the immediate must equal the sign extension of its
  // low N bits, i.e. every bit above the sign bit matches the sign bit.
  assign opc      = {opcode5_i, 2'b11};
  assign fits12   = (imm_i[31:11] == {21{imm_i[11]}});
  assign fits13   = (imm_i[31:12] == {20{imm_i[12]}});
  assign fits21   = (imm_i[31:20] == {12{imm_i[20]}});
  assign is_shift = (opcode5_i == 5'h04) &&
                    ((funct3_i == 3'b001) || (funct3_i == 3'b101));
  // ADDI sign-extends its 12-bit immediate, so LUI must pre-compensate by
  // one when bit 11 is set; the add wraps mod 2^20 on purpose.
  assign li_hi    = imm_i[31:12] + {19'b0, imm_i[11]};

  // Request encoder: word_a is the first (or only) word, word_b the
  // follow-up ADDI of a two-beat LI, req_ok the legality verdict.
  always_comb begin
    req_ok  = 1'b0;
    req_two = 1'b0;
    word_a  = '0;
    word_b  = '0;
    case (req_kind_i)
      KIND_R: begin
        req_ok = 1'b1;
        word_a = {1'b0, funct7b5_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, opc};
      end
      KIND_I: begin
        if (is_shift) begin
          req_ok = (imm_i[31:5] == '0);
          word_a = {1'b0, funct7b5_i, 5'b0, imm_i[4:0], rs1_i, funct3_i, rd_i, opc};
        end else begin
          req_ok = fits12;
          word_a = {imm_i[11:0], rs1_i, funct3_i, rd_i, opc};
        end
      end
      KIND_S: begin
        req_ok = fits12;
        word_a = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opc};
      end
      KIND_B: begin
        req_ok = fits13 && !imm_i[0];
        word_a = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                  imm_i[4:1], imm_i[11], opc};
      end
      KIND_U: begin
        req_ok = (imm_i[11:0] == 12'h000);
        word_a = {imm_i[31:12], rd_i, opc};
      end
      KIND_J: begin
        req_ok = fits21 && !imm_i[0];
        word_a = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opc};
      end
      KIND_LI: begin
        if (LI_EN) begin
          req_ok = 1'b1;
          if (fits12) begin
            word_a = {imm_i[11:0], 5'd0, 3'b000, rd_i, OPC_OP_IMM};
          end else if (imm_i[11:0] == 12'h000) begin
            word_a = {li_hi, rd_i, OPC_LUI};
          end else begin
            req_two = 1'b1;
            word_a  = {li_hi, rd_i, OPC_LUI};
            word_b  = {imm_i[11:0], rd_i, 3'b000, rd_i, OPC_OP_IMM};
          end
        end
      end
      default: begin
        req_ok = 1'b0;
      end
    endcase
  end

  assign req_ready_o = !rst_i && (state_q == S_IDLE) &&
                       (!instr_valid_q || instr_ready_i);
  assign req_accept  = req_valid_i && req_ready_o;
  assign beat_xfer   = instr_valid_q && instr_ready_i;

  // Next-state logic. A dropped request only raises invalid; whatever word
  // is already in the output register keeps its normal handshake.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    invalid_d     = 1'b0;
    addi_d        = addi_q;
    if (beat_xfer) begin
      instr_valid_d = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        if (req_accept) begin
          if (!req_ok) begin
            invalid_d = 1'b1;
          end else begin
            instr_d       = word_a;
            instr_valid_d = 1'b1;
            if (req_two) begin
              addi_d  = word_b;
              state_d = S_LI_LO;
            end
          end
        end
      end
      S_LI_LO: begin
        if (beat_xfer) begin
          instr_d       = addi_q;
          instr_valid_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset also discards a pending ADDI.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      invalid_q     <= 1'b0;
      addi_q        <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      invalid_q     <= invalid_d;
      addi_q        <= addi_d;
    end
  end

  assign instr_valid_o = instr_valid_q;
  assign instr_o       = instr_q;
  assign invalid_o     = invalid_q;

endmodule
